// File: rtl/spi_slave_core.sv
// spi_slave_core: oversampled SPI responder, all CPOL/CPHA modes, 8/16/24/32-bit MSB-first words
module spi_slave_core #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        GCLK,
    input  logic        RST,
    input  logic [1:0]  spi_mode,
    input  logic [1:0]  word_len,
    input  logic [31:0] tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic [31:0] rx_data,
    output logic        rx_valid,
    output logic        busy,
    output logic        underrun,
    output logic        overrun,
    output logic        frame_err,
    input  logic        SCK,
    input  logic        CS,
    input  logic        MOSI,
    output logic        MISO,
    output logic        MISO_oe
);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t state;
    logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
    logic sck_d, cs_d, sck_s, cs_s, mosi_s;
    logic cpol, cpha, adv, tx_full;
    logic [1:0] len, n_len;
    logic [4:0] bit_cnt, last_idx;
    logic [31:0] tx_buf, shift_tx, shift_rx, start_word, start_tx;
    logic lead, trail, sample, advance, done, cs_fall, cs_rise, hs, start;
    // Bring SCK/CS/MOSI into the GCLK domain and keep one delayed copy for edge detection
    always_ff @(posedge GCLK or posedge RST) begin
        if (RST) begin
            sck_sync <= '0;
            cs_sync <= '1;
            mosi_sync <= '0;
            sck_d <= 1'b0;
            cs_d <= 1'b1;
        end else begin
            sck_sync <= {sck_sync[SYNC_STAGES-2:0], SCK};
            cs_sync <= {cs_sync[SYNC_STAGES-2:0], CS};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
            sck_d <= sck_sync[SYNC_STAGES-1];
            cs_d <= cs_sync[SYNC_STAGES-1];
        end
    end
    // Edge classification relative to the latched CPOL, word-start decision and left-justified TX load
    always_comb begin
        sck_s = sck_sync[SYNC_STAGES-1];
        cs_s = cs_sync[SYNC_STAGES-1];
        mosi_s = mosi_sync[SYNC_STAGES-1];
        n_len = (state == IDLE) ? word_len : len;
        last_idx = {len, 3'b111};
        lead = (sck_d == cpol) && (sck_s != cpol);
        trail = (sck_d != cpol) && (sck_s == cpol);
        sample = (state == SHIFT) && (cpha ? trail : lead);
        advance = (state == SHIFT) && (cpha ? lead : (trail && adv));
        done = sample && (bit_cnt == 5'd0);
        cs_fall = cs_d && !cs_s;
        cs_rise = !cs_d && cs_s;
        hs = tx_valid && !tx_full;
        start = (state == IDLE) ? cs_fall : (done && !cs_rise);
        start_word = tx_full ? tx_buf : (hs ? tx_data : 32'h0);
        start_tx = start_word << {~n_len, 3'b000};
        tx_ready = !tx_full;
        overrun = 1'b0;
    end
    // Frame FSM: shifting, word completion, abort detection and TX buffer handling
    always_ff @(posedge GCLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            cpol <= 1'b0;
            cpha <= 1'b0;
            len <= 2'd0;
            tx_buf <= '0;
            tx_full <= 1'b0;
            shift_tx <= '0;
            shift_rx <= '0;
            bit_cnt <= '0;
            adv <= 1'b0;
            rx_data <= '0;
            rx_valid <= 1'b0;
            busy <= 1'b0;
            underrun <= 1'b0;
            frame_err <= 1'b0;
            MISO <= 1'b0;
            MISO_oe <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            underrun <= 1'b0;
            frame_err <= 1'b0;
            if (hs && !start) begin
                tx_buf <= tx_data;
                tx_full <= 1'b1;
            end
            if (state == IDLE) begin
                if (cs_fall) begin
                    cpol <= spi_mode[1];
                    cpha <= spi_mode[0];
                    len <= word_len;
                    state <= SHIFT;
                    busy <= 1'b1;
                    MISO_oe <= 1'b1;
                end
            end else begin
                if (sample) begin
                    shift_rx <= {shift_rx[30:0], mosi_s};
                    bit_cnt <= bit_cnt - 5'd1;
                    adv <= 1'b1;
                    if (bit_cnt == 5'd0) begin
                        rx_data <= {shift_rx[30:0], mosi_s};
                        rx_valid <= 1'b1;
                    end
                end
                if (advance) begin
                    MISO <= cpha ? shift_tx[31] : shift_tx[30];
                    shift_tx <= shift_tx << 1;
                    adv <= 1'b0;
                end
                if (cs_rise) begin
                    state <= IDLE;
                    busy <= 1'b0;
                    MISO_oe <= 1'b0;
                    MISO <= 1'b0;
                    frame_err <= !done && (bit_cnt != last_idx);
                end
            end
            if (start) begin
                tx_full <= 1'b0;
                underrun <= !tx_full && !hs;
                shift_tx <= start_tx;
                MISO <= start_tx[31];
                bit_cnt <= {n_len, 3'b111};
                shift_rx <= '0;
                adv <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_spi_slave_core.sv
// tb_spi_slave_core: SPI master model with a word-level reference model and per-cycle output checks
module tb_spi_slave_core;
    logic GCLK = 1'b0, RST = 1'b1;
    logic [1:0] spi_mode = 2'd0, word_len = 2'd0;
    logic [31:0] tx_data = 32'h0;
    logic tx_valid = 1'b0;
    logic tx_ready;
    logic [31:0] rx_data;
    logic rx_valid, busy, underrun, overrun, frame_err;
    logic SCK = 1'b0, CS = 1'b1, MOSI = 1'b0;
    logic MISO, MISO_oe;

    int n_chk = 0, n_fail = 0;
    logic [31:0] exp_rx[$];
    logic [31:0] exp_last = 32'h0;
    int rv_cnt = 0, ur_cnt = 0, fe_cnt = 0, cs_stable = 0;
    logic cs_prev = 1'b1;
    logic m_full = 1'b0;
    logic [31:0] m_word = 32'h0;
    logic [31:0] tx_words[4], mosi_words[4], got[4], exp_tx[5];
    int exp_ur;

    spi_slave_core #(.SYNC_STAGES(2)) dut (
        .GCLK(GCLK), .RST(RST), .spi_mode(spi_mode), .word_len(word_len),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .underrun(underrun),
        .overrun(overrun), .frame_err(frame_err), .SCK(SCK), .CS(CS), .MOSI(MOSI),
        .MISO(MISO), .MISO_oe(MISO_oe)
    );

    always #5 GCLK = ~GCLK;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge GCLK);
            #1;
        end
    endtask

    function automatic logic mbit(input int b, input int n);
        logic [31:0] wd;
        wd = mosi_words[b / n];
        return wd[n - 1 - (b % n)];
    endfunction

    // per-cycle checks: frame state follows settled CS, rx_data only changes with rx_valid
    always @(negedge GCLK) begin
        if (RST) begin
            exp_last = 32'h0;
            cs_stable = 0;
            cs_prev = CS;
        end else begin
            cs_stable = (CS == cs_prev) ? cs_stable + 1 : 0;
            cs_prev = CS;
            if (cs_stable >= 4) begin
                check("busy_vs_cs", 32'(busy), 32'(!CS));
                check("oe_vs_cs", 32'(MISO_oe), 32'(!CS));
            end
            check("overrun_zero", 32'(overrun), 32'h0);
            if (rx_valid) begin
                rv_cnt++;
                check("rx_valid_expected", 32'(exp_rx.size() != 0), 32'h1);
                if (exp_rx.size() != 0) begin
                    exp_last = exp_rx.pop_front();
                    check("rx_data_word", rx_data, exp_last);
                end
            end else
                check("rx_data_hold", rx_data, exp_last);
            ur_cnt += int'(underrun);
            fe_cnt += int'(frame_err);
        end
    end

    task automatic hs(input logic [31:0] d);
        int k;
        k = 0;
        while (!tx_ready && k < 50) begin
            tick(1);
            k++;
        end
        check("tx_ready_before_load", 32'(tx_ready), 32'h1);
        tx_data = d;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
        check("tx_ready_after_load", 32'(tx_ready), 32'h0);
        m_full = 1'b1;
        m_word = d;
    endtask

    task automatic frame(input logic [1:0] mode, input logic [1:0] len, input int nbits,
                         input int ntx, input bit preload, input int rst_at, input int h);
        int n, ti, rv0, ur0, fe0, w, i;
        logic cpol, cpha;
        logic [31:0] msk;
        n = 8 * (int'(len) + 1);
        msk = (n == 32) ? 32'hFFFF_FFFF : ((32'h1 << n) - 32'h1);
        cpol = mode[1];
        cpha = mode[0];
        spi_mode = mode;
        word_len = len;
        SCK = cpol;
        tick(4);
        ti = 0;
        exp_ur = 0;
        if (preload && !m_full && ntx > 0) begin
            hs(tx_words[0]);
            ti = 1;
        end
        for (int k = 0; k < 4; k++) got[k] = 32'h0;
        rv0 = rv_cnt;
        ur0 = ur_cnt;
        fe0 = fe_cnt;
        CS = 1'b0;
        if (!cpha) MOSI = mbit(0, n);
        tick(h);
        for (int b = 0; b <= nbits; b++) begin
            w = b / n;
            i = n - 1 - (b % n);
            if (b % n == 0) begin
                exp_tx[w] = m_full ? (m_word & msk) : 32'h0;
                if (!m_full) exp_ur++;
                m_full = 1'b0;
            end
            if (b == nbits) break;
            if (b == rst_at) begin
                RST = 1'b1;
                CS = 1'b1;
                SCK = cpol;
                #1;
                check("rst_outputs", 32'({tx_ready, rx_valid, busy, underrun, overrun, frame_err, MISO, MISO_oe}), 32'h80);
                check("rst_rx_data", rx_data, 32'h0);
                tick(3);
                RST = 1'b0;
                m_full = 1'b0;
                exp_rx.delete();
                tick(4);
                return;
            end
            SCK = ~cpol;
            if (cpha) MOSI = mbit(b, n);
            else begin
                got[w][i] = MISO;
                if (i == 0) exp_rx.push_back(mosi_words[w] & msk);
            end
            if (b % n == 2 && ti < ntx && !m_full) begin
                hs(tx_words[ti]);
                ti++;
            end
            tick(h);
            SCK = cpol;
            if (cpha) begin
                got[w][i] = MISO;
                if (i == 0) exp_rx.push_back(mosi_words[w] & msk);
            end else
                MOSI = (b + 1 < nbits) ? mbit(b + 1, n) : 1'b0;
            tick(h);
        end
        CS = 1'b1;
        tick(8);
        for (int k = 0; k < nbits / n; k++) check("miso_word", got[k], exp_tx[k]);
        check("rx_valid_count", 32'(rv_cnt - rv0), 32'(nbits / n));
        check("underrun_count", 32'(ur_cnt - ur0), 32'(exp_ur));
        check("frame_err_count", 32'(fe_cnt - fe0), 32'((nbits % n) != 0));
        check("busy_after_frame", 32'(busy), 32'h0);
        check("rx_queue_drained", 32'(exp_rx.size()), 32'h0);
        exp_rx.delete();
    endtask

    initial begin
        tick(3);
        check("reset_outputs", 32'({tx_ready, rx_valid, busy, underrun, overrun, frame_err, MISO, MISO_oe}), 32'h80);
        check("reset_rx_data", rx_data, 32'h0);
        RST = 1'b0;
        tick(4);
        // mode 0, 8-bit basic word
        tx_words[0] = 32'hA5;
        mosi_words[0] = 32'h3C;
        frame(2'd0, 2'd0, 8, 1, 1'b1, -1, 5);
        check("t1_miso", got[0], 32'hA5);
        check("t1_rx", rx_data, 32'h3C);
        // 32-bit words in modes 3, 1, 2
        for (int m = 0; m < 3; m++) begin
            tx_words[0] = 32'hDEADBEEF;
            mosi_words[0] = 32'h12345678;
            frame((m == 0) ? 2'd3 : (m == 1) ? 2'd1 : 2'd2, 2'd3, 32, 1, 1'b1, -1, 5);
            check("t2_miso", got[0], 32'hDEADBEEF);
            check("t2_rx", rx_data, 32'h12345678);
        end
        // back-to-back 16-bit words, second word loaded during the first
        tx_words[0] = 32'h1111;
        tx_words[1] = 32'h2222;
        mosi_words[0] = 32'hBEEF;
        mosi_words[1] = 32'h0F0F;
        frame(2'd0, 2'd1, 32, 2, 1'b1, -1, 4);
        check("t3_miso0", got[0], 32'h1111);
        check("t3_miso1", got[1], 32'h2222);
        check("t3_rx", rx_data, 32'h0F0F);
        // underrun: nothing loaded
        mosi_words[0] = 32'h5A;
        frame(2'd0, 2'd0, 8, 0, 1'b0, -1, 5);
        check("t4_miso", got[0], 32'h0);
        check("t4_rx", rx_data, 32'h5A);
        // abort after 10 bits of a 24-bit word, then a normal frame
        tx_words[0] = 32'h00ABCDEF;
        mosi_words[0] = 32'h00777777;
        frame(2'd1, 2'd2, 10, 1, 1'b1, -1, 5);
        check("t5_rx_unchanged", rx_data, 32'h5A);
        tx_words[0] = 32'h00C0FFEE;
        mosi_words[0] = 32'h00123456;
        frame(2'd1, 2'd2, 24, 1, 1'b1, -1, 5);
        check("t5_next_miso", got[0], 32'h00C0FFEE);
        check("t5_next_rx", rx_data, 32'h00123456);
        // reset in the middle of a 32-bit word, then a full frame
        tx_words[0] = 32'hCAFEF00D;
        mosi_words[0] = 32'h87654321;
        frame(2'd0, 2'd3, 32, 1, 1'b1, 15, 5);
        frame(2'd0, 2'd3, 32, 1, 1'b1, -1, 5);
        check("t6_miso", got[0], 32'hCAFEF00D);
        check("t6_rx", rx_data, 32'h87654321);
        // randomized frames
        repeat (24) begin
            logic [1:0] rm, rl;
            int rn, rb;
            rm = 2'($urandom_range(0, 3));
            rl = 2'($urandom_range(0, 3));
            rn = 8 * (int'(rl) + 1);
            rb = ($urandom_range(0, 3) == 0) ? (int'($urandom_range(0, 2)) * rn + int'($urandom_range(1, rn - 1)))
                                             : int'($urandom_range(1, 3)) * rn;
            for (int k = 0; k < 4; k++) begin
                tx_words[k] = $urandom;
                mosi_words[k] = $urandom;
            end
            frame(rm, rl, rb, int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), -1, int'($urandom_range(4, 7)));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
